// File: rtl/strided_addr_gen_pkg.sv
// Shared types and constants for the strided address generator.
// Holds the element-width encoding, the FSM state type and the bus-width
// legality constants.
package ava_pkg;

  typedef enum logic [1:0] {
    VSEW_8    = 2'b00,
    VSEW_16   = 2'b01,
    VSEW_32   = 2'b10,
    VSEW_RSVD = 2'b11
  } vsew_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_e;

  localparam int unsigned BUS_BYTES_NARROW = 4;
  localparam int unsigned BUS_BYTES_WIDE   = 8;

  function automatic logic bus_bytes_legal(input int unsigned bb);
    return (bb == BUS_BYTES_NARROW) || (bb == BUS_BYTES_WIDE);
  endfunction

  // Element size in bytes; the reserved code is rejected at start and
  // maps to the widest size here so alignment masks stay well defined.
  function automatic int unsigned sew_bytes(input vsew_e v);
    case (v)
      VSEW_8:  return 1;
      VSEW_16: return 2;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/strided_addr_gen_if.sv
// Command and beat-request bundle of the strided address generator.
// slave: the generator side; master: the side that issues operations and
// consumes beats.
interface strided_addr_gen_if #(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned VL_W      = 6,
  parameter int unsigned ADDR_W    = 32
);
  import ava_pkg::*;

  logic                 start_i;
  logic [ADDR_W-1:0]    base_addr_i;
  logic [ADDR_W-1:0]    stride_i;
  logic [VL_W-1:0]      vl_i;
  vsew_e                vsew_i;
  logic                 flush_i;
  logic                 ready_o;

  logic                 req_valid_o;
  logic                 req_ready_i;
  logic [ADDR_W-1:0]    req_addr_o;
  logic [BUS_BYTES-1:0] req_be_o;
  logic [VL_W-1:0]      req_elems_o;
  logic                 req_last_o;

  logic                 done_o;
  logic                 err_o;

  modport slave (
    input  start_i, base_addr_i, stride_i, vl_i, vsew_i, flush_i, req_ready_i,
    output ready_o, req_valid_o, req_addr_o, req_be_o, req_elems_o, req_last_o,
           done_o, err_o
  );

  modport master (
    output start_i, base_addr_i, stride_i, vl_i, vsew_i, flush_i, req_ready_i,
    input  ready_o, req_valid_o, req_addr_o, req_be_o, req_elems_o, req_last_o,
           done_o, err_o
  );

endinterface

// File: rtl/strided_addr_gen_be_packer.sv
// be_packer: combinational lookahead that, for the element at addr, decides
// how many consecutive elements fit in one bus beat and which byte lanes
// they touch. Packing beyond one element is enabled by ADDR_GEN_PACK_EN.
module be_packer
  import ava_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned VL_W      = 6,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic [ADDR_W-1:0]    stride,
  input  vsew_e                vsew,
  input  logic [VL_W-1:0]      remaining,
  output logic [BUS_BYTES-1:0] be,
  output logic [VL_W-1:0]      elems
);

  localparam int unsigned OFF_W = $clog2(BUS_BYTES);

  function automatic logic [BUS_BYTES-1:0] lanes(input logic [ADDR_W-1:0] a,
                                                 input int unsigned nbytes);
    logic [BUS_BYTES-1:0] m;
    int unsigned off;
    m   = '0;
    off = 32'(a[OFF_W-1:0]);
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      if ((i >= off) && (i < off + nbytes)) m[i] = 1'b1;
    end
    return m;
  endfunction

  int unsigned sb;

`ifdef ADDR_GEN_PACK_EN
  logic [ADDR_W-1:0] probe;
  logic              open;
  int unsigned       limit;
`endif

  // Lane mask and element count of the beat starting at addr.
  always_comb begin
    sb    = sew_bytes(vsew);
    be    = '0;
    elems = '0;
`ifdef ADDR_GEN_PACK_EN
    probe = addr;
    open  = 1'b1;
    limit = BUS_BYTES / sb;
`endif
    if (remaining != '0) begin
      be    = lanes(addr, sb);
      elems = VL_W'(1);
      if (stride == '0) begin
        elems = remaining;
      end
`ifdef ADDR_GEN_PACK_EN
      else begin
        // Walk forward by stride; stop at the first element that leaves the
        // starting bus word, exceeds the per-beat limit or runs out of count.
        for (int unsigned k = 1; k < BUS_BYTES; k++) begin
          probe = probe + stride;
          if (open && (k < limit) && (k < 32'(remaining)) &&
              (probe[ADDR_W-1:OFF_W] == addr[ADDR_W-1:OFF_W])) begin
            be    = be | lanes(probe, sb);
            elems = elems + VL_W'(1);
          end else begin
            open = 1'b0;
          end
        end
      end
`endif
    end
  end

endmodule

// File: rtl/strided_addr_gen.sv
// strided_addr_gen: walks base + k*stride for vl elements and emits
// bus-aligned beat requests with byte enables. Optional element packing
// into a shared beat is enabled by defining ADDR_GEN_PACK_EN.
module strided_addr_gen
  import ava_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned VL_W      = 6,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  strided_addr_gen_if.slave bus
);

  localparam int unsigned       MAX_PACK = bus_bytes_legal(BUS_BYTES) ? BUS_BYTES
                                                                      : BUS_BYTES_NARROW;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BUS_BYTES - 1);

  state_e               state;
  logic                 ready;
  logic                 req_valid;
  logic [ADDR_W-1:0]    req_addr;
  logic [BUS_BYTES-1:0] req_be;
  logic [VL_W-1:0]      req_elems;
  logic                 req_last;
  logic                 done;
  logic                 err;

  logic [ADDR_W-1:0]    stride_q;
  vsew_e                vsew_q;
  logic [ADDR_W-1:0]    nxt_addr;
  logic [VL_W-1:0]      nxt_rem;

  logic [ADDR_W-1:0]    pk_addr;
  logic [ADDR_W-1:0]    pk_stride;
  vsew_e                pk_vsew;
  logic [VL_W-1:0]      pk_rem;
  logic [BUS_BYTES-1:0] pk_be;
  logic [VL_W-1:0]      pk_elems;
  logic [ADDR_W-1:0]    step_addr;
  logic                 start_bad;
  logic                 handshake;

  // Packer looks at the command inputs while idle and at the precomputed
  // next element otherwise, so every beat is registered without a bubble.
  always_comb begin
    if (state == ST_IDLE) begin
      pk_addr   = bus.base_addr_i;
      pk_stride = bus.stride_i;
      pk_vsew   = bus.vsew_i;
      pk_rem    = bus.vl_i;
    end else begin
      pk_addr   = nxt_addr;
      pk_stride = stride_q;
      pk_vsew   = vsew_q;
      pk_rem    = nxt_rem;
    end
  end

  be_packer #(
    .BUS_BYTES (BUS_BYTES),
    .VL_W      (VL_W),
    .ADDR_W    (ADDR_W)
  ) u_be_packer (
    .addr      (pk_addr),
    .stride    (pk_stride),
    .vsew      (pk_vsew),
    .remaining (pk_rem),
    .be        (pk_be),
    .elems     (pk_elems)
  );

  // Address of the first element after this beat: running sum of stride
  // over the packed elements.
  always_comb begin
    step_addr = pk_addr;
    for (int unsigned k = 0; k < MAX_PACK; k++) begin
      if (k < 32'(pk_elems)) step_addr = step_addr + pk_stride;
    end
  end

  // Start rejection: reserved width or base not aligned to the element.
  always_comb begin
    start_bad = (bus.vsew_i == VSEW_RSVD) ||
                ((bus.base_addr_i & ADDR_W'(sew_bytes(bus.vsew_i) - 1)) != '0);
    handshake = req_valid && bus.req_ready_i;
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_be    <= '0;
      req_elems <= '0;
      req_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      stride_q  <= '0;
      vsew_q    <= VSEW_8;
      nxt_addr  <= '0;
      nxt_rem   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            if (start_bad) begin
              err <= 1'b1;
            end else if (bus.vl_i == '0) begin
              state <= ST_DONE;
              ready <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              ready     <= 1'b0;
              stride_q  <= bus.stride_i;
              vsew_q    <= bus.vsew_i;
              req_valid <= 1'b1;
              req_addr  <= pk_addr & ~OFF_MASK;
              req_be    <= pk_be;
              req_elems <= pk_elems;
              req_last  <= (pk_elems == pk_rem);
              nxt_addr  <= step_addr;
              nxt_rem   <= pk_rem - pk_elems;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.flush_i || (handshake && req_last)) begin
            state     <= bus.flush_i ? ST_IDLE : ST_DONE;
            ready     <= bus.flush_i;
            done      <= !bus.flush_i;
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_be    <= '0;
            req_elems <= '0;
            req_last  <= 1'b0;
          end else if (handshake) begin
            req_addr  <= pk_addr & ~OFF_MASK;
            req_be    <= pk_be;
            req_elems <= pk_elems;
            req_last  <= (pk_elems == pk_rem);
            nxt_addr  <= step_addr;
            nxt_rem   <= pk_rem - pk_elems;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o     = ready;
  assign bus.req_valid_o = req_valid;
  assign bus.req_addr_o  = req_addr;
  assign bus.req_be_o    = req_be;
  assign bus.req_elems_o = req_elems;
  assign bus.req_last_o  = req_last;
  assign bus.done_o      = done;
  assign bus.err_o       = err;

endmodule

// File: tb/tb_strided_addr_gen.sv
// Self-checking bench for strided_addr_gen (BUS_BYTES=4). Expected beats come
// from an element-list model; honours ADDR_GEN_PACK_EN the same way the RTL does.
module tb_strided_addr_gen;
  import ava_pkg::*;

  localparam int unsigned BB  = 4;
  localparam int unsigned VLW = 6;
  localparam int unsigned AW  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  strided_addr_gen_if #(.BUS_BYTES(BB), .VL_W(VLW), .ADDR_W(AW)) sag_bus ();

  strided_addr_gen #(.BUS_BYTES(BB), .VL_W(VLW), .ADDR_W(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sag_bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    int unsigned elems;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_lanes(input logic [31:0] a, input int unsigned sb);
    logic [3:0] m;
    int unsigned off;
    m   = '0;
    off = a % 4;
    for (int unsigned b = 0; b < sb; b++) if (off + b < 4) m[off + b] = 1'b1;
    return m;
  endfunction

  // Build the beat list from the element addresses base + k*stride.
  task automatic build_model(input logic [31:0] base, input logic [31:0] stride,
                             input int unsigned vl, input int unsigned sb);
    int unsigned i;
    int unsigned n;
    logic [31:0] a0;
    logic [31:0] an;
    logic [3:0]  be;
    beat_t       bt;
    exp_q.delete();
    i = 0;
    if (stride == 0 && vl > 0) begin
      bt.addr = base & ~32'h3; bt.be = ref_lanes(base, sb); bt.elems = vl; bt.last = 1'b1;
      exp_q.push_back(bt);
    end else begin
      while (i < vl) begin
        a0 = base + i * stride;
        n  = 1;
        be = ref_lanes(a0, sb);
`ifdef ADDR_GEN_PACK_EN
        an = base + (i + n) * stride;
        while (n < 4 / sb && i + n < vl && (an >> 2) == (a0 >> 2)) begin
          be = be | ref_lanes(an, sb);
          n++;
          an = base + (i + n) * stride;
        end
`else
        an = a0;
`endif
        bt.addr = a0 & ~32'h3; bt.be = be; bt.elems = n; bt.last = (i + n == vl);
        exp_q.push_back(bt);
        i += n;
      end
    end
  endtask

  // abort_kind: 0 none, 1 flush, 2 reset, applied while beat abort_beat is shown.
  task automatic run_op(input logic [31:0] base, input logic [31:0] stride,
                        input int unsigned vl, input int unsigned sew,
                        input int unsigned stall_pct, input int unsigned stall_beat,
                        input int unsigned abort_kind, input int unsigned abort_beat);
    int unsigned sb, cyc, beat_idx, stall_left;
    logic legal, armed, rdy;
    sb    = (sew == 0) ? 1 : (sew == 1) ? 2 : 4;
    legal = (sew != 3) && (base % sb == 0);
    if (legal) build_model(base, stride, vl, sb);
    cyc = 0;
    while (sag_bus.ready_o !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check("idle_before_start", sag_bus.ready_o, 1);
    sag_bus.base_addr_i = base;
    sag_bus.stride_i    = stride;
    sag_bus.vl_i        = VLW'(vl);
    sag_bus.vsew_i      = vsew_e'(sew[1:0]);
    sag_bus.flush_i     = 1'b0;
    sag_bus.req_ready_i = 1'b0;
    sag_bus.start_i     = 1'b1;
    @(posedge clk); #1;
    sag_bus.start_i = 1'b0;
    if (!legal) begin
      check("err_pulse", sag_bus.err_o, 1);
      check("err_ready", sag_bus.ready_o, 1);
      check("err_novalid", sag_bus.req_valid_o, 0);
      @(posedge clk); #1;
      check("err_one_cycle", sag_bus.err_o, 0);
      check("err_novalid2", sag_bus.req_valid_o, 0);
      return;
    end
    check("no_err", sag_bus.err_o, 0);
    check("busy", sag_bus.ready_o, 0);
    beat_idx = 0; stall_left = 0; armed = 1'b1; cyc = 0;
    while (cyc < 300) begin
      cyc++;
      if (exp_q.size() > 0) begin
        check("valid", sag_bus.req_valid_o, 1);
        check("addr", sag_bus.req_addr_o, exp_q[0].addr);
        check("be", sag_bus.req_be_o, exp_q[0].be);
        check("elems", sag_bus.req_elems_o, exp_q[0].elems);
        check("last", sag_bus.req_last_o, exp_q[0].last);
        check("done_early", sag_bus.done_o, 0);
        if (abort_kind != 0 && beat_idx == abort_beat) begin
          if (abort_kind == 1) sag_bus.flush_i = 1'b1; else rst = 1'b1;
          sag_bus.req_ready_i = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          sag_bus.flush_i = 1'b0; rst = 1'b0; sag_bus.req_ready_i = 1'b0; sag_bus.start_i = 1'b0;
          check("abort_valid", sag_bus.req_valid_o, 0);
          check("abort_ready", sag_bus.ready_o, 1);
          check("abort_done", sag_bus.done_o, 0);
          check("abort_addr", sag_bus.req_addr_o, 0);
          check("abort_be", sag_bus.req_be_o, 0);
          check("abort_elems", sag_bus.req_elems_o, 0);
          @(posedge clk); #1;
          check("abort_done2", sag_bus.done_o, 0);
          check("abort_valid2", sag_bus.req_valid_o, 0);
          return;
        end
        if (beat_idx == stall_beat && armed) begin stall_left = 2; armed = 1'b0; end
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
        else rdy = ($urandom_range(0, 99) >= stall_pct);
        sag_bus.req_ready_i = rdy;
        if (rdy) begin void'(exp_q.pop_front()); beat_idx++; end
        // Starts while busy must be ignored.
        sag_bus.start_i     = ($urandom_range(0, 3) == 0);
        sag_bus.base_addr_i = $urandom;
        sag_bus.vl_i        = VLW'($urandom_range(0, 9));
      end else begin
        check("end_valid", sag_bus.req_valid_o, 0);
        check("done_pulse", sag_bus.done_o, 1);
        check("end_addr", sag_bus.req_addr_o, 0);
        check("end_be", sag_bus.req_be_o, 0);
        check("done_busy", sag_bus.ready_o, 0);
        sag_bus.start_i = 1'b0; sag_bus.req_ready_i = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", sag_bus.done_o, 0);
        check("ready_after", sag_bus.ready_o, 1);
        return;
      end
      @(posedge clk); #1;
    end
    check("timeout", 1, 0);
  endtask

  initial begin
    int s;
    int unsigned sew, sb, vl, kind;
    logic [31:0] base, stride;
    rst = 1'b1;
    sag_bus.start_i = 1'b0; sag_bus.flush_i = 1'b0; sag_bus.req_ready_i = 1'b0;
    sag_bus.base_addr_i = '0; sag_bus.stride_i = '0; sag_bus.vl_i = '0;
    sag_bus.vsew_i = VSEW_8;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", sag_bus.ready_o, 1);
    check("rst_valid", sag_bus.req_valid_o, 0);
    check("rst_last", sag_bus.req_last_o, 0);
    check("rst_done", sag_bus.done_o, 0);
    check("rst_err", sag_bus.err_o, 0);
    check("rst_addr", sag_bus.req_addr_o, 0);
    check("rst_be", sag_bus.req_be_o, 0);
    check("rst_elems", sag_bus.req_elems_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h1001, 32'd1, 6, 0, 0, 99, 0, 0);
    run_op(32'h2006, 32'hFFFF_FFFE, 3, 1, 0, 99, 0, 0);
    run_op(32'h3000, 32'd8, 3, 2, 0, 1, 0, 0);
    run_op(32'h4003, 32'd0, 5, 0, 0, 99, 0, 0);
    run_op(32'h6000, 32'd4, 0, 0, 0, 99, 0, 0);
    run_op(32'h5001, 32'd2, 3, 1, 0, 99, 0, 0);
    run_op(32'h7000, 32'd4, 2, 3, 0, 99, 0, 0);
    run_op(32'h1001, 32'd1, 6, 0, 0, 99, 1, 1);
    run_op(32'h1001, 32'd1, 6, 0, 0, 99, 2, 1);
    run_op(32'hFFFF_FFFC, 32'd2, 5, 1, 20, 99, 0, 0);

    // Flush and start together in IDLE: the start is dropped.
    sag_bus.base_addr_i = 32'h8000; sag_bus.stride_i = 32'd1; sag_bus.vl_i = VLW'(3);
    sag_bus.vsew_i = VSEW_8; sag_bus.start_i = 1'b1; sag_bus.flush_i = 1'b1;
    @(posedge clk); #1;
    sag_bus.start_i = 1'b0; sag_bus.flush_i = 1'b0;
    check("flush_start_ready", sag_bus.ready_o, 1);
    check("flush_start_valid", sag_bus.req_valid_o, 0);
    check("flush_start_err", sag_bus.err_o, 0);
    @(posedge clk); #1;
    check("flush_start_valid2", sag_bus.req_valid_o, 0);
    check("flush_start_done", sag_bus.done_o, 0);

    for (int n = 0; n < 120; n++) begin
      sew  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      sb   = (sew == 0) ? 1 : (sew == 1) ? 2 : 4;
      base = $urandom;
      if ($urandom_range(0, 7) != 0) base = base & ~(sb - 1);
      s      = int'($urandom_range(0, 6)) - 3;
      stride = 32'(s * int'(sb));
      vl     = $urandom_range(0, 14);
      kind   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      run_op(base, stride, vl, sew, 30, 99, kind, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
